// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for a WIDTH-bit up-counter: load, count to limit, stop or reload.
// Optional interrupt (irq/irq_clr) enabled by defining COUNTER_SEQ_CTRL_IRQ_EN.
module counter_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             reload,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state,
    output logic             busy,
    output logic             tc
`ifdef COUNTER_SEQ_CTRL_IRQ_EN
    ,
    input  logic             irq_clr,
    output logic             irq
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic             tc_reg, tc_next;

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            tc_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            tc_reg    <= tc_next;
        end
    end

    // Priority: stop > start > pause; start is only honoured from IDLE/DONE.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        tc_next    = 1'b0;
        if (stop) begin
            state_next = ST_IDLE;
            count_next = '0;
        end else begin
            unique case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_next = ST_RUN;
                        count_next = start_val;
                    end
                end
                ST_RUN: begin
                    // Pausing defers any terminal evaluation until resumed.
                    if (pause) begin
                        state_next = ST_HOLD;
                    end else if (count_reg == limit) begin
                        tc_next = 1'b1;
                        if (reload) begin
                            count_next = start_val;
                        end else begin
                            state_next = ST_DONE;
                        end
                    end else begin
                        count_next = count_reg + CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (!pause) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign count = count_reg;
    assign state = state_reg;
    assign busy  = (state_reg == ST_RUN) || (state_reg == ST_HOLD);
    assign tc    = tc_reg;

`ifdef COUNTER_SEQ_CTRL_IRQ_EN
    logic irq_reg;

    // Set on the terminal edge dominates a coincident clear; stop leaves irq alone.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            irq_reg <= 1'b0;
        end else if (tc_next) begin
            irq_reg <= 1'b1;
        end else if (irq_clr) begin
            irq_reg <= 1'b0;
        end
    end

    assign irq = irq_reg;
`endif

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl: expected per-cycle outputs are queued
// as stimulus is planned and popped/compared one cycle after each edge.
module tb_counter_seq_ctrl;

    localparam int W = 4;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_HOLD = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

    logic         clk = 1'b0;
    logic         rest = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         pause = 1'b0;
    logic         reload = 1'b0;
    logic [W-1:0] start_val = '0;
    logic [W-1:0] limit = '0;
    logic [W-1:0] count;
    logic [1:0]   state;
    logic         busy;
    logic         tc;
`ifdef COUNTER_SEQ_CTRL_IRQ_EN
    logic         irq_clr = 1'b0;
    logic         irq;
`endif

    counter_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rest      (rest),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .reload    (reload),
        .start_val (start_val),
        .limit     (limit),
        .count     (count),
        .state     (state),
        .busy      (busy),
        .tc        (tc)
`ifdef COUNTER_SEQ_CTRL_IRQ_EN
        ,
        .irq_clr   (irq_clr),
        .irq       (irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] count;
        logic [1:0]   state;
        logic         tc;
        logic         busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic exp_t mk(int c, logic [1:0] s, logic t, logic b);
        exp_t e;
        e.count = W'(c);
        e.state = s;
        e.tc    = t;
        e.busy  = b;
        return e;
    endfunction

    function automatic exp_t obs();
        return exp_t'({count, state, tc, busy});
    endfunction

    function automatic string fmt(exp_t e);
        return $sformatf("count=%0d state=%0d tc=%0b busy=%0b", e.count, e.state, e.tc, e.busy);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, o;
        rest = 1'b0;
        start = 1'b1;
        start_val = 4'd9;
        exp_q.push_back(mk(0, S_IDLE, 0, 0));
        exp_q.push_back(mk(0, S_IDLE, 0, 0));
        exp_q.push_back(mk(0, S_IDLE, 0, 0));
        #2;
        for (int j = 0; j < 3; j++) begin
            if (j == 1) tick();
            if (j == 2) begin
                #3 rest = 1'b1;
                start = 1'b0;
                tick();
            end
            e = exp_q.pop_front();
            o = obs();
            n_cmp++;
            $display("reset cyc%0d %s", j, fmt(o));
            if (o !== e) begin
                n_err++;
                $display("FAIL reset cyc%0d: got %s want %s", j, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_oneshot();
        exp_t e, o;
        start_val = 4'd3;
        limit = 4'd7;
        reload = 1'b0;
        for (int v = 3; v <= 7; v++) exp_q.push_back(mk(v, S_RUN, 0, 1));
        exp_q.push_back(mk(7, S_DONE, 1, 0));
        exp_q.push_back(mk(7, S_DONE, 0, 0));
        exp_q.push_back(mk(7, S_DONE, 0, 0));
        for (int j = 0; j < 8; j++) begin
            start = (j == 0);
            tick();
            e = exp_q.pop_front();
            o = obs();
            n_cmp++;
            $display("oneshot cyc%0d %s", j, fmt(o));
            if (o !== e) begin
                n_err++;
                $display("FAIL oneshot cyc%0d: got %s want %s", j, fmt(o), fmt(e));
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reload_wrap();
        exp_t e, o;
        logic [W-1:0] pat [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
        start_val = 4'd14;
        limit = 4'd1;
        reload = 1'b1;
        for (int i = 0; i < 12; i++)
            exp_q.push_back(mk(int'(pat[i % 4]), S_RUN, (i > 0) && (i % 4 == 0), 1));
        exp_q.push_back(mk(5, S_RUN, 1, 1));
        exp_q.push_back(mk(6, S_RUN, 0, 1));
        exp_q.push_back(mk(0, S_IDLE, 0, 0));
        for (int j = 0; j < 15; j++) begin
            start = (j == 0);
            stop = (j == 14);
            if (j == 11) start_val = 4'd5;
            tick();
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL reload_wrap cyc%0d: scoreboard empty", j);
            end else begin
                e = exp_q.pop_front();
                o = obs();
                n_cmp++;
                $display("reload_wrap cyc%0d %s", j, fmt(o));
                if (o !== e) begin
                    n_err++;
                    $display("FAIL reload_wrap cyc%0d: got %s want %s", j, fmt(o), fmt(e));
                end
            end
        end
        stop = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_pause();
        exp_t e, o;
        start_val = 4'd0;
        limit = 4'd15;
        reload = 1'b0;
        for (int v = 0; v <= 5; v++) exp_q.push_back(mk(v, S_RUN, 0, 1));
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(5, S_HOLD, 0, 1));
        exp_q.push_back(mk(5, S_RUN, 0, 1));
        exp_q.push_back(mk(6, S_RUN, 0, 1));
        exp_q.push_back(mk(7, S_RUN, 0, 1));
        exp_q.push_back(mk(8, S_RUN, 0, 1));
        exp_q.push_back(mk(0, S_IDLE, 0, 0));
        exp_q.push_back(mk(9, S_RUN, 0, 1));
        exp_q.push_back(mk(9, S_HOLD, 0, 1));
        exp_q.push_back(mk(9, S_RUN, 0, 1));
        exp_q.push_back(mk(9, S_DONE, 1, 0));
        exp_q.push_back(mk(9, S_DONE, 0, 0));
        for (int j = 0; j < 19; j++) begin
            start = (j == 0) || (j == 7) || (j == 12) || (j == 14);
            pause = (j >= 6 && j <= 8) || (j == 14) || (j == 15);
            stop = (j == 13);
            if (j == 7) start_val = 4'd12;
            if (j == 14) begin
                start_val = 4'd9;
                limit = 4'd9;
            end
            tick();
            e = exp_q.pop_front();
            o = obs();
            n_cmp++;
            $display("pause cyc%0d %s", j, fmt(o));
            if (o !== e) begin
                n_err++;
                $display("FAIL pause cyc%0d: got %s want %s", j, fmt(o), fmt(e));
            end
        end
        start = 1'b0;
        pause = 1'b0;
        stop = 1'b0;
    endtask

    task automatic test_stop_start();
        exp_t e, o;
        start_val = 4'd2;
        limit = 4'd10;
        reload = 1'b0;
        exp_q.push_back(mk(2, S_RUN, 0, 1));
        exp_q.push_back(mk(3, S_RUN, 0, 1));
        exp_q.push_back(mk(0, S_IDLE, 0, 0));
        exp_q.push_back(mk(0, S_IDLE, 0, 0));
        exp_q.push_back(mk(4, S_RUN, 0, 1));
        exp_q.push_back(mk(4, S_RUN, 1, 1));
        exp_q.push_back(mk(0, S_IDLE, 0, 0));
        for (int j = 0; j < 7; j++) begin
            start = (j == 0) || (j == 2) || (j == 4);
            stop = (j == 2) || (j == 6);
            if (j == 4) begin
                start_val = 4'd4;
                limit = 4'd4;
                reload = 1'b1;
            end
            tick();
            e = exp_q.pop_front();
            o = obs();
            n_cmp++;
            $display("stop_start cyc%0d %s", j, fmt(o));
            if (o !== e) begin
                n_err++;
                $display("FAIL stop_start cyc%0d: got %s want %s", j, fmt(o), fmt(e));
            end
        end
        start = 1'b0;
        stop = 1'b0;
    endtask

    task automatic test_async_reset();
        exp_t e, o;
        start_val = 4'd2;
        limit = 4'd2;
        reload = 1'b1;
        exp_q.push_back(mk(2, S_RUN, 0, 1));
        exp_q.push_back(mk(2, S_RUN, 1, 1));
        exp_q.push_back(mk(0, S_IDLE, 0, 0));
        exp_q.push_back(mk(0, S_IDLE, 0, 0));
        exp_q.push_back(mk(0, S_IDLE, 0, 0));
        exp_q.push_back(mk(6, S_RUN, 0, 1));
        for (int j = 0; j < 6; j++) begin
            start = (j == 0) || (j == 5);
            if (j == 2) begin
                #3 rest = 1'b0;
                #1;
            end else begin
                if (j == 3) #2 rest = 1'b1;
                if (j == 5) begin
                    start_val = 4'd6;
                    limit = 4'd7;
                    reload = 1'b0;
                end
                tick();
            end
            e = exp_q.pop_front();
            o = obs();
            n_cmp++;
            $display("async_reset cyc%0d %s", j, fmt(o));
            if (o !== e) begin
                n_err++;
                $display("FAIL async_reset cyc%0d: got %s want %s", j, fmt(o), fmt(e));
            end
        end
        start = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

`ifdef COUNTER_SEQ_CTRL_IRQ_EN
    task automatic test_irq();
        logic irq_q[$];
        logic ei;
        n_cmp++;
        $display("irq init irq=%0b", irq);
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq init: got %0b want 0", irq);
        end
        start_val = 4'd3;
        limit = 4'd7;
        reload = 1'b0;
        for (int i = 0; i < 5; i++) irq_q.push_back(1'b0);
        irq_q.push_back(1'b1);
        irq_q.push_back(1'b1);
        irq_q.push_back(1'b1);
        irq_q.push_back(1'b0);
        irq_q.push_back(1'b0);
        irq_q.push_back(1'b1);
        irq_q.push_back(1'b1);
        irq_q.push_back(1'b0);
        for (int j = 0; j < 13; j++) begin
            start = (j == 0) || (j == 9);
            stop = (j == 7) || (j == 12);
            irq_clr = (j == 8) || (j == 11) || (j == 12);
            if (j == 9) begin
                start_val = 4'd5;
                limit = 4'd5;
                reload = 1'b1;
            end
            tick();
            ei = irq_q.pop_front();
            n_cmp++;
            $display("irq cyc%0d irq=%0b tc=%0b", j, irq, tc);
            if (irq !== ei) begin
                n_err++;
                $display("FAIL irq cyc%0d: got %0b want %0b", j, irq, ei);
            end
        end
        start = 1'b0;
        stop = 1'b0;
        irq_clr = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_oneshot();
        test_reload_wrap();
        test_pause();
        test_stop_start();
        test_async_reset();
`ifdef COUNTER_SEQ_CTRL_IRQ_EN
        test_irq();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
